reaction_counter: RTL and testbench

Measures the user's reaction time in the reaction timer. Sits downstream of the countdown block: once a trial is armed, it waits for `countdown_finish`, lights the stimulus LED, and counts 1 ms ticks until the player's button press. It reports the result in binary and 4-digit BCD for the display, and flags false starts (press before stimulus) and timeouts.

---
 rtl/reaction_counter_if.sv | 30 +++
 rtl/reaction_counter.sv | 163 ++++++++++++++++
 tb/tb_reaction_counter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_counter_if.sv
// Player-facing signal bundle of the reaction timer measurement block.
// The slave side is the reaction_counter; the master side drives arm/countdown/button.
interface reaction_counter_if;
   logic        arm;
   logic        countdown_finish;
   logic        button;
   logic        led;
   logic        busy;
   logic        done;
   logic        valid;
   logic        false_start;
   logic        timeout;
   logic [13:0] result_ms;
   logic [15:0] result_bcd;
   logic [13:0] best_ms;
   logic [15:0] best_bcd;
   logic        best_valid;

   modport master (
      output arm, countdown_finish, button,
      input  led, busy, done, valid, false_start, timeout,
      input  result_ms, result_bcd, best_ms, best_bcd, best_valid
   );

   modport slave (
      input  arm, countdown_finish, button,
      output led, busy, done, valid, false_start, timeout,
      output result_ms, result_bcd, best_ms, best_bcd, best_valid
   );
endinterface

// File: rtl/reaction_counter.sv
// Reaction-time measurement: waits for countdown_finish, lights the LED, counts 1 ms ticks
// until a button press. Optional best-time tracking enabled by REACTION_BEST_TIME_EN.
module reaction_counter #(
   parameter int unsigned TIMEOUT_MS = 2000
) (
   input logic               clk1k,
   input logic               reset,
   reaction_counter_if.slave bus
);

   localparam logic [13:0] TimeoutCnt = 14'(TIMEOUT_MS);

   typedef enum logic [1:0] {StIdle, StArmed, StTiming, StDone} state_e;

   state_e      state_q, state_d;
   logic        s1_q, s2_q, s3_q;
   logic        press;
   logic [13:0] count_q, count_d;
   logic [15:0] bcd_q, bcd_d;
   logic [13:0] result_ms_q, result_ms_d;
   logic [15:0] result_bcd_q, result_bcd_d;
   logic        false_start_q, false_start_d;
   logic        timeout_q, timeout_d;
   logic        done_q, done_d;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // s3 trails s2 so a held button yields exactly one press
   assign press = s2_q & ~s3_q;

   always_ff @(posedge clk1k or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         count_q       <= '0;
         bcd_q         <= '0;
         result_ms_q   <= '0;
         result_bcd_q  <= '0;
         false_start_q <= 1'b0;
         timeout_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         s1_q          <= bus.button;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         count_q       <= count_d;
         bcd_q         <= bcd_d;
         result_ms_q   <= result_ms_d;
         result_bcd_q  <= result_bcd_d;
         false_start_q <= false_start_d;
         timeout_q     <= timeout_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      bcd_d         = bcd_q;
      result_ms_d   = result_ms_q;
      result_bcd_d  = result_bcd_q;
      false_start_d = false_start_q;
      timeout_d     = timeout_q;
      done_d        = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (bus.arm) begin
               state_d       = StArmed;
               count_d       = '0;
               bcd_d         = '0;
               result_ms_d   = '0;
               result_bcd_d  = '0;
               false_start_d = 1'b0;
               timeout_d     = 1'b0;
            end
         end
         StArmed: begin
            // press beats a simultaneous countdown_finish
            if (press) begin
               state_d       = StDone;
               false_start_d = 1'b1;
               result_ms_d   = '0;
               result_bcd_d  = '0;
               done_d        = 1'b1;
            end else if (bus.countdown_finish) begin
               state_d = StTiming;
               count_d = '0;
               bcd_d   = '0;
            end
         end
         StTiming: begin
            if (press || count_q == TimeoutCnt) begin
               state_d      = StDone;
               result_ms_d  = count_q;
               result_bcd_d = bcd_q;
               timeout_d    = ~press;
               done_d       = 1'b1;
            end else begin
               count_d = count_q + 14'd1;
               bcd_d   = bcd_inc(bcd_q);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.led         = (state_q == StTiming);
   assign bus.busy        = (state_q == StArmed) || (state_q == StTiming);
   assign bus.done        = done_q;
   assign bus.valid       = (state_q == StDone);
   assign bus.false_start = false_start_q;
   assign bus.timeout     = timeout_q;
   assign bus.result_ms   = result_ms_q;
   assign bus.result_bcd  = result_bcd_q;

`ifdef REACTION_BEST_TIME_EN
   logic [13:0] best_ms_q;
   logic [15:0] best_bcd_q;
   logic        best_valid_q;

   // Compares the latched result the cycle after done; ties keep the older best
   always_ff @(posedge clk1k or posedge reset) begin
      if (reset) begin
         best_ms_q    <= '0;
         best_bcd_q   <= '0;
         best_valid_q <= 1'b0;
      end else if (done_q && !false_start_q && !timeout_q &&
                   (!best_valid_q || result_ms_q < best_ms_q)) begin
         best_ms_q    <= result_ms_q;
         best_bcd_q   <= result_bcd_q;
         best_valid_q <= 1'b1;
      end
   end

   assign bus.best_ms    = best_ms_q;
   assign bus.best_bcd   = best_bcd_q;
   assign bus.best_valid = best_valid_q;
`else
   assign bus.best_ms    = '0;
   assign bus.best_bcd   = '0;
   assign bus.best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_counter.sv
// Self-checking bench for reaction_counter: trials described by input edge offsets,
// expected outcome derived arithmetically from the timing rules.
module tb_reaction_counter;

   localparam int unsigned TMO = 2000;
`ifdef REACTION_BEST_TIME_EN
   localparam bit BEST_EN = 1'b1;
`else
   localparam bit BEST_EN = 1'b0;
`endif

   logic clk1k = 1'b0;
   logic reset;
   reaction_counter_if bus ();

   reaction_counter #(.TIMEOUT_MS(TMO)) dut (
      .clk1k (clk1k),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk1k = ~clk1k;

   int n_cmp = 0;
   int n_bad = 0;
   int best_m = 0;
   bit best_v = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] b;
      b[15:12] = 4'((v / 1000) % 10);
      b[11:8]  = 4'((v / 100) % 10);
      b[7:4]   = 4'((v / 10) % 10);
      b[3:0]   = 4'(v % 10);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk1k);
      #1;
   endtask

   task automatic test_reset();
      logic [77:0] got;
      bus.arm = 1'b0;
      bus.countdown_finish = 1'b0;
      bus.button = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         got = {bus.led, bus.busy, bus.done, bus.valid, bus.false_start, bus.timeout,
                bus.result_ms, bus.result_bcd, bus.best_ms, bus.best_bcd, bus.best_valid};
         n_cmp++;
         if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_state[%0d] got %h want 0", i, got);
         end
         reset = 1'b0;
         tick();
      end
      best_v = 1'b0;
      best_m = 0;
      repeat (3) tick();
   endtask

   // Offsets count edges after the edge that samples arm (edge 0).
   task automatic run_trial(input string name, input int cf_off, input int btn_off);
      int done_edge, res, noise, t;
      bit fs, to;
      logic [3:0] exp_ctl, got_ctl;
      logic [13:0] exp_bm;
      logic [15:0] exp_bb;
      logic exp_bv;
      if (btn_off + 2 <= cf_off) begin
         fs = 1'b1; to = 1'b0; res = 0; done_edge = btn_off + 2;
      end else begin
         fs = 1'b0;
         t = cf_off;
         res = btn_off - t + 1;
         if (res > int'(TMO)) begin
            to = 1'b1; res = TMO; done_edge = t + TMO + 1;
         end else begin
            to = 1'b0; done_edge = btn_off + 2;
         end
      end
      noise = $urandom_range(done_edge, 1);
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      for (int e = 1; e <= done_edge + 1; e++) begin
         bus.countdown_finish = (e >= cf_off);
         bus.button = (e >= btn_off);
         bus.arm = (e == noise);
         tick();
         exp_ctl = {!fs && e >= cf_off && e < done_edge, e < done_edge, e == done_edge,
                    e >= done_edge};
         got_ctl = {bus.led, bus.busy, bus.done, bus.valid};
         n_cmp++;
         if (got_ctl !== exp_ctl) begin
            n_bad++;
            $display("FAIL %s ctl e=%0d led/busy/done/valid got %b want %b",
                     name, e, got_ctl, exp_ctl);
         end
         if (e == done_edge + 1 && !fs && !to && (!best_v || res < best_m)) begin
            best_m = res;
            best_v = 1'b1;
         end
         if (e == done_edge) begin
            n_cmp++;
            if (bus.result_ms !== 14'(res) || bus.result_bcd !== to_bcd(res) ||
                bus.false_start !== fs || bus.timeout !== to) begin
               n_bad++;
               $display("FAIL %s result got %0d/%h fs=%b to=%b want %0d/%h fs=%b to=%b", name,
                        bus.result_ms, bus.result_bcd, bus.false_start, bus.timeout,
                        res, to_bcd(res), fs, to);
            end
         end
         if (e >= done_edge) begin
            exp_bm = BEST_EN ? 14'(best_m) : 14'd0;
            exp_bb = BEST_EN ? to_bcd(best_m) : 16'h0;
            exp_bv = BEST_EN && best_v;
            n_cmp++;
            if (bus.best_ms !== exp_bm || bus.best_bcd !== exp_bb || bus.best_valid !== exp_bv)
            begin
               n_bad++;
               $display("FAIL %s best e=%0d got %0d/%h/%b want %0d/%h/%b", name, e,
                        bus.best_ms, bus.best_bcd, bus.best_valid, exp_bm, exp_bb, exp_bv);
            end
         end
      end
      bus.arm = 1'b0;
      bus.countdown_finish = 1'b0;
      bus.button = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_normal();
      run_trial("normal_251", 100, 350);
   endtask

   task automatic test_false_start();
      run_trial("false_early", 50, 10);
      run_trial("false_same_cycle", 50, 48);
      run_trial("press_one_late", 50, 49);
   endtask

   task automatic test_timeout();
      run_trial("timeout", 5, 5 + 3000);
      run_trial("press_on_last", 7, 7 + int'(TMO) - 1);
   endtask

   task automatic test_bcd_carry();
      run_trial("bcd_1099", 3, 3 + 1098);
      run_trial("bcd_999", 4, 4 + 998);
      run_trial("bcd_1000", 2, 2 + 999);
   endtask

   task automatic test_best();
      test_reset();
      run_trial("best_300", 20, 20 + 299);
      run_trial("best_180", 15, 15 + 179);
      run_trial("best_180_tie", 30, 30 + 179);
      run_trial("best_false", 40, 5);
   endtask

   task automatic test_back_to_back();
      int cf, btn;
      for (int i = 0; i < 8; i++) begin
         cf = $urandom_range(300, 1);
         btn = $urandom_range(cf + 400, 1);
         run_trial($sformatf("random_%0d", i), cf, btn);
      end
   endtask

   task automatic test_reset_mid();
      logic [77:0] got;
      logic [3:0] got_ctl;
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      bus.countdown_finish = 1'b1;
      tick();
      bus.countdown_finish = 1'b0;
      repeat (57) tick();
      bus.button = 1'b1;
      #2 reset = 1'b1;
      #1;
      got = {bus.led, bus.busy, bus.done, bus.valid, bus.false_start, bus.timeout,
             bus.result_ms, bus.result_bcd, bus.best_ms, bus.best_bcd, bus.best_valid};
      n_cmp++;
      if (got !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_state got %h want 0", got);
      end
      best_v = 1'b0;
      best_m = 0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      bus.countdown_finish = 1'b1;
      repeat (6) tick();
      got_ctl = {bus.led, bus.busy, bus.done, bus.valid};
      n_cmp++;
      if (got_ctl !== 4'b1100 || bus.false_start !== 1'b0) begin
         n_bad++;
         $display("FAIL held_button ctl got %b fs=%b want 1100 fs=0", got_ctl, bus.false_start);
      end
      bus.countdown_finish = 1'b0;
      bus.button = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      run_trial("after_reset", 10, 60);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_false_start();
      test_timeout();
      test_bcd_carry();
      test_best();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
